// File: rtl/ps2_synth_key_decoder.sv
// PS/2 Set-2 scan-code decoder: note/gate, one-shot octave and ADSR step pulses, ADSR selector.
// Outputs are registered and update on the edge that samples rx_valid.
module ps2_synth_key_decoder #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] note,
  output logic       note_in,
  output logic       octave_plus_plus,
  output logic       octave_minus_minus,
  output logic [2:0] adsr_selector,
  output logic       adsr_plus_plus,
  output logic       adsr_minus_minus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          timeout;
  logic          is_make, is_break;
  logic          note_hit, sel_hit, ctl_hit;
  logic [3:0]    note_code;
  logic [2:0]    sel_code;
  logic [1:0]    ctl_idx;
  // held[0]=X (octave+), held[1]=Z (octave-), held[2]='=' (adsr+), held[3]='-' (adsr-)
  logic [3:0]    held;

  assign timeout = (state != IDLE) && (cnt == TO_MAX);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    is_make  = 1'b0;
    is_break = 1'b0;
    if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_data == 8'hF0)      state_nx = BRK;
          else if (rx_data == 8'hE0) state_nx = EXT;
          else                       is_make  = 1'b1;
        end
        BRK: begin
          if (rx_data == 8'hF0)      state_nx = BRK;
          else if (rx_data == 8'hE0) state_nx = EXT_BRK;
          else begin
            is_break = 1'b1;
            state_nx = IDLE;
          end
        end
        EXT:     state_nx = (rx_data == 8'hF0) ? EXT_BRK : IDLE;
        default: state_nx = IDLE;
      endcase
    end else if (timeout) begin
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || rx_valid || state == IDLE || timeout) cnt <= '0;
    else                                                 cnt <= cnt + 1'b1;
  end

  always_comb begin
    note_hit  = 1'b1;
    note_code = 4'd0;
    sel_hit   = 1'b1;
    sel_code  = 3'd0;
    ctl_hit   = 1'b1;
    ctl_idx   = 2'd0;
    case (rx_data)
      8'h1C: note_code = 4'd0;
      8'h1D: note_code = 4'd1;
      8'h1B: note_code = 4'd2;
      8'h24: note_code = 4'd3;
      8'h23: note_code = 4'd4;
      8'h2B: note_code = 4'd5;
      8'h2C: note_code = 4'd6;
      8'h34: note_code = 4'd7;
      8'h35: note_code = 4'd8;
      8'h33: note_code = 4'd9;
      8'h3C: note_code = 4'd10;
      8'h3B: note_code = 4'd11;
      default: note_hit = 1'b0;
    endcase
    case (rx_data)
      8'h16: sel_code = 3'd0;
      8'h1E: sel_code = 3'd1;
      8'h26: sel_code = 3'd2;
      8'h25: sel_code = 3'd3;
      8'h2E: sel_code = 3'd4;
      default: sel_hit = 1'b0;
    endcase
    case (rx_data)
      8'h22: ctl_idx = 2'd0;
      8'h1A: ctl_idx = 2'd1;
      8'h55: ctl_idx = 2'd2;
      8'h4E: ctl_idx = 2'd3;
      default: ctl_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      note               <= 4'd0;
      note_in            <= 1'b0;
      adsr_selector      <= 3'd0;
      held               <= 4'd0;
      octave_plus_plus   <= 1'b0;
      octave_minus_minus <= 1'b0;
      adsr_plus_plus     <= 1'b0;
      adsr_minus_minus   <= 1'b0;
    end else begin
      octave_plus_plus   <= 1'b0;
      octave_minus_minus <= 1'b0;
      adsr_plus_plus     <= 1'b0;
      adsr_minus_minus   <= 1'b0;
      if (is_make) begin
        if (note_hit) begin
          note    <= note_code;
          note_in <= 1'b1;
        end
        if (sel_hit) adsr_selector <= sel_code;
        // Typematic repeats arrive as makes while held; only the first one pulses.
        if (ctl_hit && !held[ctl_idx]) begin
          held[ctl_idx] <= 1'b1;
          case (ctl_idx)
            2'd0:    octave_plus_plus   <= 1'b1;
            2'd1:    octave_minus_minus <= 1'b1;
            2'd2:    adsr_plus_plus     <= 1'b1;
            default: adsr_minus_minus   <= 1'b1;
          endcase
        end
      end
      if (is_break) begin
        if (note_hit && note_code == note) note_in <= 1'b0;
        if (ctl_hit) held[ctl_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_synth_key_decoder.sv
// Scoreboard bench: driver feeds scan-code bytes through a key-level model; monitor compares each cycle.
module tb_ps2_synth_key_decoder;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [3:0] note;
  logic       note_in;
  logic       octave_plus_plus, octave_minus_minus;
  logic [2:0] adsr_selector;
  logic       adsr_plus_plus, adsr_minus_minus;

  ps2_synth_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .note(note), .note_in(note_in),
    .octave_plus_plus(octave_plus_plus), .octave_minus_minus(octave_minus_minus),
    .adsr_selector(adsr_selector),
    .adsr_plus_plus(adsr_plus_plus), .adsr_minus_minus(adsr_minus_minus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected output vector: {note, gate, selector, oct+, oct-, adsr+, adsr-}
  logic [11:0] exp_q[$];
  logic [11:0] last_exp = '0;
  logic        checking = 1'b0;

  // Reference model state: key-level view of the keyboard
  logic [7:0] note_keys[12] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                                8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B};
  logic [7:0] sel_keys[5]   = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
  logic [7:0] ctl_keys[4]   = '{8'h22, 8'h1A, 8'h55, 8'h4E};
  bit         m_break_pfx, m_ext_pfx;
  int         m_note, m_sel, last_edge;
  bit         m_gate;
  bit         m_held[4];
  bit         m_pulse[4];

  function automatic logic [11:0] model_out();
    return {4'(m_note), m_gate, 3'(m_sel), m_pulse[0], m_pulse[1], m_pulse[2], m_pulse[3]};
  endfunction

  function automatic void model_reset();
    m_break_pfx = 0; m_ext_pfx = 0;
    m_note = 0; m_gate = 0; m_sel = 0;
    for (int i = 0; i < 4; i++) begin m_held[i] = 0; m_pulse[i] = 0; end
  endfunction

  function automatic void model_key(input logic [7:0] b, input bit is_make);
    for (int i = 0; i < 12; i++)
      if (note_keys[i] == b) begin
        if (is_make) begin m_note = i; m_gate = 1; end
        else if (m_note == i) m_gate = 0;
      end
    for (int i = 0; i < 5; i++)
      if (sel_keys[i] == b && is_make) m_sel = i;
    for (int i = 0; i < 4; i++)
      if (ctl_keys[i] == b) begin
        if (is_make && !m_held[i]) m_pulse[i] = 1;
        m_held[i] = is_make;
      end
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) m_pulse[i] = 0;
    if (m_ext_pfx) begin
      if (b == 8'hF0 && !m_break_pfx) m_break_pfx = 1;
      else begin m_ext_pfx = 0; m_break_pfx = 0; end
    end else if (m_break_pfx) begin
      if (b == 8'hE0) m_ext_pfx = 1;
      else if (b != 8'hF0) begin model_key(b, 0); m_break_pfx = 0; end
    end else begin
      if (b == 8'hF0) m_break_pfx = 1;
      else if (b == 8'hE0) m_ext_pfx = 1;
      else model_key(b, 1);
    end
  endfunction

  // Called just after a falling edge.
  task automatic send_byte(input logic [7:0] b);
    int edge_no;
    edge_no = cyc + 1;
    // A prefix is abandoned once the gap to the next byte exceeds the timeout.
    if ((m_break_pfx || m_ext_pfx) && (edge_no - last_edge) > TO) begin
      m_break_pfx = 0; m_ext_pfx = 0;
    end
    last_edge = edge_no;
    model_byte(b);
    exp_q.push_back(model_out());
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    exp_q.push_back(model_out());
    checking = 1'b1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  always @(posedge clk) begin
    logic        strobe;
    logic [11:0] act, exp;
    strobe = !reset || rx_valid;
    #1;
    act = {note, note_in, adsr_selector, octave_plus_plus, octave_minus_minus,
           adsr_plus_plus, adsr_minus_minus};
    if (checking) begin
      n_checks++;
      if (strobe) begin
        if (exp_q.size() == 0) begin
          n_fails++;
          $display("FAIL strobe_no_expect: got %h, no expectation queued", act);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            n_fails++;
            $display("FAIL strobe t=%0t: got %h required %h (note,gate,sel,o+,o-,a+,a-)", $time, act, exp);
          end
          last_exp = {exp[11:4], 4'b0000};
        end
      end else if (act !== last_exp) begin
        n_fails++;
        $display("FAIL hold t=%0t: got %h required %h (note,gate,sel,o+,o-,a+,a-)", $time, act, last_exp);
      end
    end
  end

  logic [7:0] pool[25] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34, 8'h35,
                           8'h33, 8'h3C, 8'h3B, 8'h22, 8'h1A, 8'h55, 8'h4E, 8'h16, 8'h1E,
                           8'h26, 8'h25, 8'h2E, 8'hF0, 8'hF0, 8'hF0, 8'hE0};

  initial begin
    model_reset();
    last_edge = 0;
    @(negedge clk);
    do_reset();
    idle(2);
    send_seq('{8'h1C, 8'hF0, 8'h1C});
    idle(1);
    send_seq('{8'h22, 8'h22, 8'h22, 8'hF0, 8'h22, 8'h22});
    idle(1);
    send_seq('{8'h1C, 8'h3B, 8'hF0, 8'h1C});
    send_seq('{8'hF0, 8'h3B});
    send_seq('{8'h26, 8'h55, 8'hF0, 8'h55, 8'hE0, 8'h55});
    // Prefix abandoned after a long idle gap
    send_byte(8'hF0);
    idle(20);
    send_byte(8'h1A);
    send_seq('{8'hF0, 8'h1A});
    // Gap exactly at the timeout boundary keeps the prefix
    send_byte(8'hF0);
    idle(TO - 1);
    send_byte(8'h1A);
    send_byte(8'h1C);
    send_byte(8'hF0);
    do_reset();
    send_byte(8'h1C);
    send_seq('{8'h22, 8'hF0});
    do_reset();
    send_byte(8'h22);
    for (int i = 0; i < 500; i++) begin
      logic [7:0] b;
      int r;
      r = $urandom_range(0, 99);
      b = (r < 8) ? 8'($urandom) : pool[$urandom_range(0, 24)];
      send_byte(b);
      r = $urandom_range(0, 99);
      if (r < 5)       idle($urandom_range(TO - 2, TO + 2));
      else if (r < 40) idle($urandom_range(1, 3));
      if ($urandom_range(0, 199) == 0) do_reset();
    end
    idle(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
